// File: rtl/braille_pkg.sv
// Shared FSM encoding and default timing constants for the braille SPI master.
// The half-period count is fixed at 16 per byte, so its terminal value lives here too.
package braille_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT,
    ST_HOLD,
    ST_LATCH
  } state_t;

  localparam int DEFAULT_CLK_DIV      = 4;
  localparam int DEFAULT_LATCH_CYCLES = 2;

  localparam logic [3:0] LAST_HALF_PERIOD = 4'd15;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses tick every CLK_DIV enabled cycles.
// The count restarts from zero whenever en is low, so each state entry gets a full period.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = en && (cnt_reg == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (!en || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/braille_spi_master.sv
// SPI mode 0 master feeding a braille cell controller, with an optional
// active-low latch strobe after each frame. Pin outputs are registered.
module braille_spi_master
  import braille_pkg::*;
#(
  parameter int CLK_DIV      = DEFAULT_CLK_DIV,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_latch,
  output logic       in_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  output logic       ss_n,
  input  logic       miso,
  output logic       latch_data_n
);

  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [LW-1:0] LAT_END = LW'(LATCH_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [3:0]    hp_reg, hp_next;
  logic [7:0]    tx_reg, tx_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic [7:0]    rx_data_reg, rx_data_next;
  logic          rx_valid_reg, rx_valid_next;
  logic          last_reg, last_next;
  logic          latch_reg, latch_next;
  logic [LW-1:0] lat_cnt_reg, lat_cnt_next;
  logic          sclk_reg, ss_n_reg, latch_n_reg;
  logic          div_en, tick;

  assign div_en = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT) || (state_reg == ST_HOLD);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clock(clock),
    .reset(reset),
    .en   (div_en),
    .tick (tick)
  );

  assign in_ready     = (state_reg == ST_IDLE) || (state_reg == ST_WAIT);
  assign busy         = (state_reg != ST_IDLE);
  assign mosi         = tx_reg[7];
  assign sclk         = sclk_reg;
  assign ss_n         = ss_n_reg;
  assign latch_data_n = latch_n_reg;
  assign rx_valid     = rx_valid_reg;
  assign rx_data      = rx_data_reg;

  always_comb begin
    state_next    = state_reg;
    hp_next       = hp_reg;
    tx_next       = tx_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    last_next     = last_reg;
    latch_next    = latch_reg;
    lat_cnt_next  = lat_cnt_reg;
    case (state_reg)
      ST_IDLE, ST_WAIT: begin
        if (in_valid) begin
          tx_next    = in_data;
          last_next  = in_last;
          latch_next = in_latch;
          hp_next    = 4'd0;
          state_next = (state_reg == ST_IDLE) ? ST_SETUP : ST_SHIFT;
        end
      end
      ST_SETUP: begin
        if (tick) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Even half-periods are sclk low: their end is a rising edge (sample),
        // odd ones end in a falling edge (advance mosi).
        if (tick) begin
          if (!hp_reg[0]) rx_shift_next = {rx_shift_reg[6:0], miso};
          else            tx_next       = {tx_reg[6:0], 1'b0};
          if (hp_reg == LAST_HALF_PERIOD) begin
            rx_valid_next = 1'b1;
            rx_data_next  = rx_shift_reg;
            hp_next       = 4'd0;
            state_next    = last_reg ? ST_HOLD : ST_WAIT;
          end else begin
            hp_next = hp_reg + 4'd1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) state_next = latch_reg ? ST_LATCH : ST_IDLE;
      end
      ST_LATCH: begin
        if (lat_cnt_reg == LAT_END) begin
          lat_cnt_next = '0;
          state_next   = ST_IDLE;
        end else begin
          lat_cnt_next = lat_cnt_reg + LW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      hp_reg       <= 4'd0;
      tx_reg       <= 8'd0;
      rx_shift_reg <= 8'd0;
      rx_data_reg  <= 8'd0;
      rx_valid_reg <= 1'b0;
      last_reg     <= 1'b0;
      latch_reg    <= 1'b0;
      lat_cnt_reg  <= '0;
      sclk_reg     <= 1'b0;
      ss_n_reg     <= 1'b1;
      latch_n_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      hp_reg       <= hp_next;
      tx_reg       <= tx_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      last_reg     <= last_next;
      latch_reg    <= latch_next;
      lat_cnt_reg  <= lat_cnt_next;
      // Pins follow the next state so they switch on the same edge as the FSM.
      sclk_reg     <= (state_next == ST_SHIFT) && hp_next[0];
      ss_n_reg     <= (state_next == ST_IDLE) || (state_next == ST_LATCH);
      latch_n_reg  <= (state_next != ST_LATCH);
    end
  end

endmodule
